// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Holds the ALU select codes, the default operation count and the
// sequencer FSM state encoding.
package alu_op_sequencer_pkg;

  localparam int unsigned N_OPS = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD,
    FINISH
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus between the sequencer and its requester/consumer.
//   start, a_in, b_in, op_mask : batch request (requester -> sequencer)
//   res_valid/res_ready        : result beat handshake
//   res_op, res_y, res_err     : result beat payload
//   busy, done, err_cnt        : batch status
// slave  : sequencer side
// master : requester/consumer side
interface alu_op_sequencer_if
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned N_OPS = alu_op_sequencer_pkg::N_OPS
) ();

  logic             start;
  logic [3:0]       a_in;
  logic [3:0]       b_in;
  logic [N_OPS-1:0] op_mask;
  logic             res_valid;
  logic             res_ready;
  logic [2:0]       res_op;
  logic [3:0]       res_y;
  logic             res_err;
  logic             busy;
  logic             done;
  logic [3:0]       err_cnt;

  modport slave (
    input  start, a_in, b_in, op_mask, res_ready,
    output res_valid, res_op, res_y, res_err, busy, done, err_cnt
  );

  modport master (
    output start, a_in, b_in, op_mask, res_ready,
    input  res_valid, res_op, res_y, res_err, busy, done, err_cnt
  );

endinterface

// File: rtl/alu_op_sequencer_alu.sv
// alu_4bit: combinational 4-bit ALU.
//   a, b : operands
//   sel  : operation select (OP_ADD..OP_XOR)
//   y    : result, truncated to 4 bits; unknown selects give 0
module alu_4bit
  import alu_op_sequencer_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs a batch of ALU operations selected by a mask,
// one result beat per selected op, in ascending select order, each beat
// checked against an in-module reference model.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request / result / status bus (slave side)
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned N_OPS = alu_op_sequencer_pkg::N_OPS
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus
);

  state_e           state_q, state_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [N_OPS-1:0] mask_q, mask_d;
  logic [2:0]       res_op_q, res_op_d;
  logic [3:0]       res_y_q, res_y_d;
  logic             res_err_q, res_err_d;
  logic [3:0]       err_cnt_q, err_cnt_d;

  logic [2:0]       sel;
  logic [3:0]       alu_y;
  logic             mismatch;

  // Scans from the top down so the lowest set bit is the last one written.
  function automatic logic [2:0] lowest_idx(input logic [N_OPS-1:0] m);
    lowest_idx = '0;
    for (int unsigned k = N_OPS; k > 0; k--) begin
      if (m[k-1]) lowest_idx = 3'(k - 1);
    end
  endfunction

  // Reference model, written independently of alu_4bit.
  function automatic logic [3:0] ref_alu(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [2:0] op);
    ref_alu = '0;
    case (op)
      OP_ADD:  ref_alu = a + b;
      OP_SUB:  ref_alu = a + (~b) + 4'd1;
      OP_AND:  ref_alu = ~(~a | ~b);
      OP_OR:   ref_alu = ~(~a & ~b);
      OP_XOR:  ref_alu = (a & ~b) | (~a & b);
      default: ref_alu = '0;
    endcase
  endfunction

  assign sel      = lowest_idx(mask_q);
  assign mismatch = (alu_y != ref_alu(a_q, b_q, sel));

  alu_4bit u_alu (
    .a   (a_q),
    .b   (b_q),
    .sel (sel),
    .y   (alu_y)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mask_d    = mask_q;
    res_op_d  = res_op_q;
    res_y_d   = res_y_q;
    res_err_d = res_err_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d       = bus.a_in;
          b_d       = bus.b_in;
          mask_d    = bus.op_mask;
          err_cnt_d = '0;
          state_d   = (bus.op_mask == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        res_y_d   = alu_y;
        res_op_d  = sel;
        res_err_d = mismatch;
        if (mismatch && (err_cnt_q != 4'hF)) err_cnt_d = err_cnt_q + 4'd1;
        // m & (m - 1) clears exactly the lowest set bit, i.e. the op just run.
        mask_d    = mask_q & (mask_q - N_OPS'(1));
        state_d   = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) state_d = (mask_q != '0) ? ISSUE : FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mask_q    <= '0;
      res_op_q  <= '0;
      res_y_q   <= '0;
      res_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mask_q    <= mask_d;
      res_op_q  <= res_op_d;
      res_y_q   <= res_y_d;
      res_err_q <= res_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.res_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FINISH);
  assign bus.res_op    = res_op_q;
  assign bus.res_y     = res_y_q;
  assign bus.res_err   = res_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   beat_cnt = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] y;
  } beat_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] m;
    logic [3:0] y0;
  } vec_t;

  beat_t      sb[$];
  logic [3:0] seen_q[$];
  vec_t       tbl[7];

  alu_op_sequencer_if #(.N_OPS(5)) bus ();

  alu_op_sequencer #(.N_OPS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] tb_alu(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  // Beat monitor: a beat is taken on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      beat_t e;
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("beat_op", 32'(bus.res_op), 32'(e.op));
        chk("beat_y", 32'(bus.res_y), 32'(e.y));
        chk("beat_err", 32'(bus.res_err), 0);
      end
      seen_q.push_back(bus.res_y);
      beat_cnt++;
      hs_cyc = cyc;
    end
  end

  task automatic push_expected(input logic [3:0] a, input logic [3:0] b, input logic [4:0] m);
    for (int k = 0; k < 5; k++) begin
      if (m[k]) sb.push_back('{op: 3'(k), y: tb_alu(a, b, 3'(k))});
    end
  endtask

  // lat = negedge index (after the start edge) where res_valid first seen;
  // ndone = negedge index where done seen. Both 0 if not seen.
  task automatic wait_done(output int lat, output int ndone);
    lat = 0;
    ndone = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (bus.res_valid && lat == 0) lat = n;
      if (bus.done) begin
        ndone = n;
        break;
      end
    end
    if (ndone == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        seen = 1;
        break;
      end
    end
    chk(name, 32'(seen), 1);
  endtask

  task automatic run_batch(input logic [3:0] a, input logic [3:0] b, input logic [4:0] m,
                           input logic [3:0] y0, input bit chk_first);
    int lat, nd, beats0;
    beats0 = beat_cnt;
    seen_q.delete();
    push_expected(a, b, m);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b; bus.op_mask = m; bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, nd);
    if (m != 5'd0) begin
      // Valid is first visible in the cycle after the second edge past acceptance.
      chk("first_latency", lat, 3);
      chk("done_after_last_hs", cyc - hs_cyc, 1);
    end else begin
      chk("zero_mask_no_valid", lat, 0);
      chk("zero_mask_done_cycle", nd, 1);
      chk("zero_mask_busy", 32'(bus.busy), 1);
    end
    chk("err_cnt", 32'(bus.err_cnt), 0);
    chk("beat_count", beat_cnt - beats0, $countones(m));
    chk("sb_empty", sb.size(), 0);
    if (chk_first)
      chk("first_y", (seen_q.size() > 0) ? 32'(seen_q[0]) : 32'hDEAD, 32'(y0));
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("busy_after", 32'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{a: 4'd5,  b: 4'd3,  m: 5'b11111, y0: 4'd8};
    tbl[1] = '{a: 4'd12, b: 4'd7,  m: 5'b00001, y0: 4'd3};
    tbl[2] = '{a: 4'd3,  b: 4'd5,  m: 5'b00010, y0: 4'd14};
    tbl[3] = '{a: 4'd15, b: 4'd15, m: 5'b10101, y0: 4'd14};
    tbl[4] = '{a: 4'd9,  b: 4'd10, m: 5'b01010, y0: 4'd15};
    tbl[5] = '{a: 4'd6,  b: 4'd12, m: 5'b01100, y0: 4'd4};
    tbl[6] = '{a: 4'd10, b: 4'd5,  m: 5'b10000, y0: 4'd15};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.op_mask = '0; bus.res_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_op_y_err_cnt", {bus.res_op, bus.res_y, bus.res_err, bus.err_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_batch(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].y0, 1'b1);

    // Empty mask: straight to FINISH.
    run_batch(4'd7, 4'd9, 5'b00000, 4'd0, 1'b0);

    for (int i = 0; i < 4; i++)
      run_batch(4'($urandom_range(15)), 4'($urandom_range(15)), 5'($urandom_range(1, 31)), 4'd0, 1'b0);

    // Backpressure on the first beat.
    begin
      int lat, nd, beats0;
      beats0 = beat_cnt;
      push_expected(4'd5, 4'd3, 5'b00011);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a_in = 4'd5; bus.b_in = 4'd3; bus.op_mask = 5'b00011; bus.res_ready = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_valid("bp_valid_seen");
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        chk("bp_valid_held", 32'(bus.res_valid), 1);
        chk("bp_op_held", 32'(bus.res_op), 0);
        chk("bp_y_held", 32'(bus.res_y), 8);
      end
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      wait_done(lat, nd);
      chk("bp_beat_count", beat_cnt - beats0, 2);
      chk("bp_sb_empty", sb.size(), 0);
      @(negedge clk);
    end

    // Start pulsed mid-batch with other operands must be ignored.
    begin
      int lat, nd;
      push_expected(4'd5, 4'd3, 5'b11111);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a_in = 4'd5; bus.b_in = 4'd3; bus.op_mask = 5'b11111; bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      bus.start = 1'b1; bus.a_in = 4'd9; bus.b_in = 4'd1; bus.op_mask = 5'b00001;
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(lat, nd);
      chk("ign_sb_empty", sb.size(), 0);
      chk("ign_err_cnt", 32'(bus.err_cnt), 0);
      @(negedge clk);
    end

    // Reset while holding the second beat.
    begin
      push_expected(4'd5, 4'd3, 5'b11111);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a_in = 4'd5; bus.b_in = 4'd3; bus.op_mask = 5'b11111; bus.res_ready = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_valid("rst_seq_beat1");
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      wait_valid("rst_seq_beat2");
      chk("rst_seq_beat2_op", 32'(bus.res_op), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(bus.res_valid), 0);
      chk("midrst_busy_done", {bus.busy, bus.done}, 0);
      chk("midrst_op_y_err_cnt", {bus.res_op, bus.res_y, bus.res_err, bus.err_cnt}, 0);
      sb.delete();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        chk("post_rst_no_done", {bus.done, bus.busy, bus.res_valid}, 0);
      end
      run_batch(4'd5, 4'd3, 5'b11111, 4'd8, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
